// File: rtl/pix_gen_pkg.sv
// Shared types and constants for the AR0134 pixel-bus emulator.
package pix_gen_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFvLead,
        StLine,
        StHblank,
        StFvTrail,
        StVblank
    } state_e;

    localparam logic [1:0] MODE_RAMP   = 2'd0;
    localparam logic [1:0] MODE_BAYER  = 2'd1;
    localparam logic [1:0] MODE_MOVING = 2'd2;
    localparam logic [1:0] MODE_FIXED  = 2'd3;

    localparam logic [9:0] BAYER_G = 10'h200;
    localparam logic [9:0] BAYER_R = 10'h3FF;
    localparam logic [9:0] BAYER_B = 10'h100;

    // Width of a counter that runs 0..n-1, never less than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pix_pattern.sv
// Registered test-pattern generator; data is forced to zero outside line valid.
module pix_pattern
    import pix_gen_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [9:0] col_i,
    input  logic [9:0] row_i,
    input  logic [9:0] frame_i,
    input  logic [1:0] mode_i,
    input  logic [9:0] fixed_i,
    input  logic       lv_i,
    output logic [9:0] data_o
);

    logic [9:0] data_d;
    logic [9:0] data_q;

    always_comb begin
        data_d = '0;
        if (lv_i) begin
            unique case (mode_i)
                MODE_RAMP:   data_d = col_i;
                MODE_BAYER: begin
                    // GRBG: even rows G/R, odd rows B/G.
                    unique case ({row_i[0], col_i[0]})
                        2'b00:   data_d = BAYER_G;
                        2'b01:   data_d = BAYER_R;
                        2'b10:   data_d = BAYER_B;
                        default: data_d = BAYER_G;
                    endcase
                end
                MODE_MOVING: data_d = col_i + row_i + frame_i;
                default:     data_d = fixed_i;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/ar0134_pix_gen.sv
// AR0134 parallel-output emulator: frame/line timing FSM driving the pattern generator.
module ar0134_pix_gen
    import pix_gen_pkg::*;
#(
    parameter int unsigned H_ACTIVE = 1280,
    parameter int unsigned H_BLANK  = 370,
    parameter int unsigned V_ACTIVE = 960,
    parameter int unsigned FV_LEAD  = 16,
    parameter int unsigned FV_TRAIL = 16,
    parameter int unsigned V_BLANK  = 4000
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic        iEnable,
    input  logic [1:0]  ivMode,
    input  logic [9:0]  ivFixedValue,
    output logic        oPixFV,
    output logic        oPixLV,
    output logic [9:0]  ovPixData,
    output logic [15:0] ovFrameCount,
    output logic        oBusy
);

    localparam int unsigned MAX_A     = (H_BLANK > V_BLANK) ? H_BLANK : V_BLANK;
    localparam int unsigned MAX_B     = (FV_LEAD > FV_TRAIL) ? FV_LEAD : FV_TRAIL;
    localparam int unsigned BLANK_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned CW        = cnt_w(H_ACTIVE);
    localparam int unsigned RW        = cnt_w(V_ACTIVE);
    localparam int unsigned BW        = cnt_w(BLANK_MAX);

    state_e          state_q, state_d;
    logic [BW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   col_q, col_d;
    logic [RW-1:0]   row_q, row_d;
    logic [15:0]     frame_q, frame_d;
    logic [1:0]      mode_q, mode_d;
    logic [9:0]      fixed_q, fixed_d;
    logic            fv_q, lv_q, busy_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        col_d   = col_q;
        row_d   = row_q;
        frame_d = frame_q;
        mode_d  = mode_q;
        fixed_d = fixed_q;
        unique case (state_q)
            StIdle: begin
                if (iEnable) begin
                    state_d = StFvLead;
                    cnt_d   = '0;
                    row_d   = '0;
                    col_d   = '0;
                    mode_d  = ivMode;
                    fixed_d = ivFixedValue;
                end
            end
            StFvLead: begin
                if (cnt_q == BW'(FV_LEAD - 1)) begin
                    state_d = StLine;
                    cnt_d   = '0;
                    col_d   = '0;
                end else begin
                    cnt_d = cnt_q + BW'(1);
                end
            end
            StLine: begin
                if (col_q == CW'(H_ACTIVE - 1)) begin
                    cnt_d = '0;
                    // The last line goes straight to the trailer without a blank.
                    if (row_q == RW'(V_ACTIVE - 1)) begin
                        state_d = StFvTrail;
                    end else begin
                        state_d = StHblank;
                        row_d   = row_q + RW'(1);
                    end
                end else begin
                    col_d = col_q + CW'(1);
                end
            end
            StHblank: begin
                if (cnt_q == BW'(H_BLANK - 1)) begin
                    state_d = StLine;
                    cnt_d   = '0;
                    col_d   = '0;
                end else begin
                    cnt_d = cnt_q + BW'(1);
                end
            end
            StFvTrail: begin
                if (cnt_q == BW'(FV_TRAIL - 1)) begin
                    state_d = StVblank;
                    cnt_d   = '0;
                    frame_d = frame_q + 16'd1;
                end else begin
                    cnt_d = cnt_q + BW'(1);
                end
            end
            StVblank: begin
                if (cnt_q == BW'(V_BLANK - 1)) begin
                    cnt_d = '0;
                    if (iEnable) begin
                        state_d = StFvLead;
                        row_d   = '0;
                        col_d   = '0;
                        mode_d  = ivMode;
                        fixed_d = ivFixedValue;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q + BW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            col_q   <= '0;
            row_q   <= '0;
            frame_q <= '0;
            mode_q  <= '0;
            fixed_q <= '0;
            fv_q    <= 1'b0;
            lv_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            col_q   <= col_d;
            row_q   <= row_d;
            frame_q <= frame_d;
            mode_q  <= mode_d;
            fixed_q <= fixed_d;
            fv_q    <= (state_d != StIdle) && (state_d != StVblank);
            lv_q    <= (state_d == StLine);
            busy_q  <= (state_d != StIdle);
        end
    end

    // Pattern is fed next-state values so its registered output lines up with lv_q.
    pix_pattern u_pattern (
        .clk_i   (iClk),
        .rst_i   (iRst),
        .col_i   (10'(col_d)),
        .row_i   (10'(row_d)),
        .frame_i (frame_d[9:0]),
        .mode_i  (mode_d),
        .fixed_i (fixed_d),
        .lv_i    (state_d == StLine),
        .data_o  (ovPixData)
    );

    assign oPixFV       = fv_q;
    assign oPixLV       = lv_q;
    assign ovFrameCount = frame_q;
    assign oBusy        = busy_q;

endmodule

// File: tb/tb_ar0134_pix_gen.sv
// Self-checking bench for ar0134_pix_gen using a pixel scoreboard with a small timing.
module tb_ar0134_pix_gen;

    localparam int H = 8, HB = 4, V = 4, FL = 2, FT = 2, VB = 3;
    localparam int SPAN = 48, PERIOD = 51;

    logic        clk = 1'b0;
    logic        rst, en;
    logic [1:0]  mode;
    logic [9:0]  fx;
    logic        fv, lv, busy;
    logic [9:0]  data;
    logic [15:0] fc;

    int n_tests = 0;
    int n_fail  = 0;
    logic [9:0] sb[$];

    logic        fv_a[PERIOD];
    logic        lv_a[PERIOD];
    logic        busy_a[PERIOD];
    logic [9:0]  dat_a[PERIOD];
    logic [15:0] fc_a[PERIOD];

    always #5 clk = ~clk;

    ar0134_pix_gen #(
        .H_ACTIVE (H),
        .H_BLANK  (HB),
        .V_ACTIVE (V),
        .FV_LEAD  (FL),
        .FV_TRAIL (FT),
        .V_BLANK  (VB)
    ) dut (
        .iClk         (clk),
        .iRst         (rst),
        .iEnable      (en),
        .ivMode       (mode),
        .ivFixedValue (fx),
        .oPixFV       (fv),
        .oPixLV       (lv),
        .ovPixData    (data),
        .ovFrameCount (fc),
        .oBusy        (busy)
    );

    function automatic logic [9:0] exp_pix(input logic [1:0] m, input int c, input int r,
                                           input int f, input logic [9:0] fixv);
        case (m)
            2'd0: return 10'(c);
            2'd1: begin
                if (r % 2 == 0) return (c % 2 == 0) ? 10'h200 : 10'h3FF;
                else            return (c % 2 == 0) ? 10'h100 : 10'h200;
            end
            2'd2: return 10'(c + r + f);
            default: return fixv;
        endcase
    endfunction

    task automatic push_frame(input logic [1:0] m, input int f, input logic [9:0] fixv);
        for (int r = 0; r < V; r++)
            for (int c = 0; c < H; c++)
                sb.push_back(exp_pix(m, c, r, f, fixv));
    endtask

    // Records one frame period of outputs; optionally drops enable or changes mode mid-frame.
    task automatic capture_frame(input int drop_at, input int chg_at, input logic [1:0] chg_mode,
                                 input logic [9:0] chg_fx);
        for (int i = 0; i < PERIOD; i++) begin
            @(negedge clk);
            fv_a[i]   = fv;
            lv_a[i]   = lv;
            busy_a[i] = busy;
            dat_a[i]  = data;
            fc_a[i]   = fc;
            if (i == drop_at) en = 1'b0;
            if (i == chg_at) begin
                mode = chg_mode;
                fx   = chg_fx;
            end
        end
    endtask

    task automatic test_reset;
        rst  = 1'b1;
        en   = 1'b0;
        mode = 2'd0;
        fx   = 10'd0;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({fv, lv, busy, data, fc} !== 29'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: fv=%b lv=%b busy=%b data=%h fc=%h, required all 0",
                     fv, lv, busy, data, fc);
        end
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || fv !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_hold: busy=%b fv=%b, required 0 0", busy, fv);
        end
    endtask

    task automatic test_ramp;
        int fv_n, lv_n, pulses, bad_blank;
        logic prev;
        logic [9:0] e;
        en   = 1'b1;
        mode = 2'd0;
        push_frame(2'd0, 0, 10'd0);
        capture_frame(-1, -1, 2'd0, 10'd0);
        fv_n = 0; lv_n = 0; pulses = 0; bad_blank = 0; prev = 1'b0;
        for (int i = 0; i < PERIOD; i++) begin
            if (fv_a[i]) fv_n++;
            if (lv_a[i]) begin
                lv_n++;
                if (!prev) pulses++;
                n_tests++;
                e = sb.pop_front();
                if (dat_a[i] !== e) begin
                    n_fail++;
                    $display("FAIL ramp_data[%0d]: got %h, required %h", i, dat_a[i], e);
                end
            end else if (dat_a[i] !== 10'd0) bad_blank++;
            prev = lv_a[i];
        end
        n_tests++;
        if (fv_n != SPAN || fv_a[0] !== 1'b1 || fv_a[SPAN-1] !== 1'b1 || fv_a[SPAN] !== 1'b0) begin
            n_fail++;
            $display("FAIL ramp_fv_span: %0d high cycles, required %0d from first cycle", fv_n, SPAN);
        end
        n_tests++;
        if (lv_n != V * H || pulses != V) begin
            n_fail++;
            $display("FAIL ramp_lv: %0d cycles in %0d pulses, required %0d in %0d",
                     lv_n, pulses, V * H, V);
        end
        n_tests++;
        if (lv_a[FL-1] !== 1'b0 || lv_a[FL] !== 1'b1) begin
            n_fail++;
            $display("FAIL ramp_lead: lv[%0d]=%b lv[%0d]=%b, required 0 1",
                     FL - 1, lv_a[FL-1], FL, lv_a[FL]);
        end
        n_tests++;
        if (fc_a[SPAN-1] !== 16'd0 || fc_a[SPAN] !== 16'd1) begin
            n_fail++;
            $display("FAIL ramp_frame_count: %0d then %0d at FV fall, required 0 then 1",
                     fc_a[SPAN-1], fc_a[SPAN]);
        end
        n_tests++;
        if (bad_blank != 0) begin
            n_fail++;
            $display("FAIL ramp_blank_zero: %0d nonzero blank samples, required 0", bad_blank);
        end
    endtask

    task automatic test_bayer;
        int bad_blank;
        logic [9:0] e;
        mode = 2'd1;
        push_frame(2'd1, 1, 10'd0);
        capture_frame(-1, -1, 2'd0, 10'd0);
        bad_blank = 0;
        for (int i = 0; i < PERIOD; i++) begin
            if (lv_a[i]) begin
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL bayer_extra[%0d]: got %h, required no pixel", i, dat_a[i]);
                end else begin
                    e = sb.pop_front();
                    if (dat_a[i] !== e) begin
                        n_fail++;
                        $display("FAIL bayer_data[%0d]: got %h, required %h", i, dat_a[i], e);
                    end
                end
            end else if (dat_a[i] !== 10'd0) bad_blank++;
        end
        n_tests++;
        if (bad_blank != 0 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL bayer_blank: %0d nonzero blank, %0d missing pixels, required 0 0",
                     bad_blank, sb.size());
        end
        sb.delete();
    endtask

    task automatic test_moving;
        logic [9:0] e;
        rst = 1'b1;
        @(negedge clk);
        rst  = 1'b0;
        en   = 1'b1;
        mode = 2'd2;
        for (int k = 0; k < 3; k++) begin
            push_frame(2'd2, k, 10'd0);
            capture_frame(-1, -1, 2'd0, 10'd0);
            for (int i = 0; i < PERIOD; i++) begin
                if (lv_a[i] && sb.size() != 0) begin
                    n_tests++;
                    e = sb.pop_front();
                    if (dat_a[i] !== e) begin
                        n_fail++;
                        $display("FAIL moving_f%0d[%0d]: got %h, required %h", k, i, dat_a[i], e);
                    end
                end
            end
            n_tests++;
            if (sb.size() != 0) begin
                n_fail++;
                $display("FAIL moving_count_f%0d: %0d pixels missing, required 0", k, sb.size());
                sb.delete();
            end
        end
        // Frame 2, row 3, col 7 is the last LV sample of the window.
        n_tests++;
        if (dat_a[45] !== 10'd12 || lv_a[45] !== 1'b1) begin
            n_fail++;
            $display("FAIL moving_corner: got lv=%b data=%0d, required lv=1 data=12",
                     lv_a[45], dat_a[45]);
        end
    endtask

    task automatic test_enable_drop;
        int fv_n, lv_n, late_fv;
        rst = 1'b1;
        @(negedge clk);
        rst  = 1'b0;
        en   = 1'b1;
        mode = 2'd0;
        capture_frame(10, -1, 2'd0, 10'd0);
        fv_n = 0; lv_n = 0;
        for (int i = 0; i < PERIOD; i++) begin
            if (fv_a[i]) fv_n++;
            if (lv_a[i]) lv_n++;
        end
        n_tests++;
        if (fv_n != SPAN || lv_n != V * H) begin
            n_fail++;
            $display("FAIL drop_full_frame: fv=%0d lv=%0d, required %0d %0d", fv_n, lv_n, SPAN, V * H);
        end
        n_tests++;
        if (busy_a[PERIOD-1] !== 1'b1) begin
            n_fail++;
            $display("FAIL drop_vblank_busy: busy=%b in last VBLANK cycle, required 1",
                     busy_a[PERIOD-1]);
        end
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || fv !== 1'b0 || fc !== 16'd1) begin
            n_fail++;
            $display("FAIL drop_idle: busy=%b fv=%b fc=%0d, required 0 0 1", busy, fv, fc);
        end
        late_fv = 0;
        repeat (6) begin
            @(negedge clk);
            if (fv !== 1'b0 || busy !== 1'b0) late_fv++;
        end
        n_tests++;
        if (late_fv != 0) begin
            n_fail++;
            $display("FAIL drop_stays_idle: %0d active cycles, required 0", late_fv);
        end
    endtask

    task automatic test_mode_change;
        logic [9:0] e;
        en   = 1'b1;
        mode = 2'd0;
        fx   = 10'd0;
        push_frame(2'd0, 0, 10'd0);
        capture_frame(-1, 10, 2'd3, 10'h155);
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 1) begin
                push_frame(2'd3, 0, 10'h155);
                capture_frame(-1, -1, 2'd0, 10'd0);
                mode = 2'd3;
            end
            for (int i = 0; i < PERIOD; i++) begin
                if (lv_a[i] && sb.size() != 0) begin
                    n_tests++;
                    e = sb.pop_front();
                    if (dat_a[i] !== e) begin
                        n_fail++;
                        $display("FAIL mode_change_p%0d[%0d]: got %h, required %h",
                                 pass, i, dat_a[i], e);
                    end
                end
            end
            n_tests++;
            if (sb.size() != 0) begin
                n_fail++;
                $display("FAIL mode_change_count_p%0d: %0d pixels missing, required 0",
                         pass, sb.size());
                sb.delete();
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [9:0] e;
        int fv_n;
        repeat (30) @(negedge clk);
        n_tests++;
        if (lv !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_in_line: lv=%b before reset, required 1", lv);
        end
        rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({fv, lv, busy, data, fc} !== 29'd0) begin
            n_fail++;
            $display("FAIL rst_mid_outputs: fv=%b lv=%b busy=%b data=%h fc=%h, required all 0",
                     fv, lv, busy, data, fc);
        end
        rst  = 1'b0;
        en   = 1'b1;
        mode = 2'd0;
        push_frame(2'd0, 0, 10'd0);
        capture_frame(-1, -1, 2'd0, 10'd0);
        fv_n = 0;
        for (int i = 0; i < PERIOD; i++) begin
            if (fv_a[i]) fv_n++;
            if (lv_a[i] && sb.size() != 0) begin
                n_tests++;
                e = sb.pop_front();
                if (dat_a[i] !== e) begin
                    n_fail++;
                    $display("FAIL rst_mid_data[%0d]: got %h, required %h", i, dat_a[i], e);
                end
            end
        end
        n_tests++;
        if (sb.size() != 0 || fv_n != SPAN) begin
            n_fail++;
            $display("FAIL rst_mid_frame: %0d missing, fv=%0d, required 0 and %0d",
                     sb.size(), fv_n, SPAN);
            sb.delete();
        end
        n_tests++;
        if (fc_a[0] !== 16'd0 || fc_a[SPAN] !== 16'd1) begin
            n_fail++;
            $display("FAIL rst_mid_frame_count: %0d then %0d, required 0 then 1",
                     fc_a[0], fc_a[SPAN]);
        end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_bayer();
        test_moving();
        test_enable_drop();
        test_mode_change();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
